pc_redirect_unit: RTL

Front-end program-counter generator. It owns the PC register and produces the sequential (PC+INC) and redirect (branch target) candidates that the next-PC select mux chooses between. It applies EX-stage branch redirects, honours hazard stalls, holds a redirect that arrives during a stall, and issues a one-cycle IF/ID flush after every applied redirect.

---
 rtl/pc_redirect_unit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/pc_redirect_unit.sv
// Front-end PC generator: owns the fetch PC, applies EX-stage redirects, defers them across stalls, flushes IF/ID.
// Latency: unstalled redirect lands in pc_out 1 cycle later; a stalled one lands 1 cycle after stall drops.
// Backpressure: stall freezes the PC; a redirect arriving under stall is held (youngest wins), never dropped.
module pc_redirect_unit #(
   parameter int                     PC_WIDTH  = 32,
   parameter logic [PC_WIDTH-1:0]    RESET_PC  = '0,
   parameter int                     INC       = 4,
   parameter int                     CNT_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  branch_taken,
   input  logic [PC_WIDTH-1:0]   branch_target,
   output logic [PC_WIDTH-1:0]   pc_out,
   output logic [PC_WIDTH-1:0]   pc_plus_inc,
   output logic                  fetch_valid,
   output logic                  flush_ifid,
   output logic                  redirect_pending,
   output logic                  misalign_err,
   output logic [CNT_WIDTH-1:0]  redirect_count
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [PC_WIDTH-1:0]    pc_q, pc_d;
   logic [PC_WIDTH-1:0]    held_q, held_d;
   logic                   flush_q, flush_d;
   logic                   mis_q, mis_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

   logic [PC_WIDTH-1:0]    eff_target;
   logic                   tgt_misaligned;
   logic                   apply_redirect;

   // Word-align the incoming target; low bits only feed the sticky error flag.
   assign eff_target     = {branch_target[PC_WIDTH-1:2], 2'b00};
   assign tgt_misaligned = (branch_target[1:0] != 2'b00);
   assign pc_plus_inc    = pc_q + PC_WIDTH'(INC);

   // Next-state, next-PC and bookkeeping for the three fetch phases.
   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      held_d         = held_q;
      mis_d          = mis_q;
      apply_redirect = 1'b0;

      case (state_q)
         BOOT: begin
            // First cycle out of reset: PC stays at RESET_PC, branches ignored.
            state_d = RUN;
         end
         RUN: begin
            if (branch_taken) begin
               if (tgt_misaligned) mis_d = 1'b1;
               if (stall) begin
                  held_d  = eff_target;
                  state_d = HOLD;
               end else begin
                  pc_d           = eff_target;
                  apply_redirect = 1'b1;
               end
            end else if (!stall) begin
               pc_d = pc_plus_inc;
            end
         end
         HOLD: begin
            if (branch_taken && tgt_misaligned) mis_d = 1'b1;
            if (stall) begin
               // Youngest request replaces the parked one.
               if (branch_taken) held_d = eff_target;
            end else begin
               pc_d           = branch_taken ? eff_target : held_q;
               apply_redirect = 1'b1;
               state_d        = RUN;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase

      flush_d = apply_redirect;
      cnt_d   = cnt_q;
      if (apply_redirect && (cnt_q != {CNT_WIDTH{1'b1}})) cnt_d = cnt_q + CNT_WIDTH'(1);
   end

   // State and datapath registers; reset discards any parked redirect.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         held_q  <= '0;
         flush_q <= 1'b0;
         mis_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         held_q  <= held_d;
         flush_q <= flush_d;
         mis_q   <= mis_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pc_out           = pc_q;
   assign fetch_valid      = (state_q != BOOT);
   assign flush_ifid       = flush_q;
   assign redirect_pending = (state_q == HOLD);
   assign misalign_err     = mis_q;
   assign redirect_count   = cnt_q;

endmodule
